// File: rtl/dma_ctrl.sv
// dma_ctrl: single-channel byte DMA for an 8-bit CPU bus.
// The CPU programs SRC/DST/LEN/CTRL/FILL through an 8-byte register window
// and writes START.  The controller stalls the CPU through cpu_rdy and owns
// the bus for the whole transfer.  It copies one byte per READ/WRITE pair.
// In fill mode it writes one byte per cycle.
// Optional feature macro: DMA_FILL_EN.  It enables FILL_MODE and the FILL
// register.  Without it every START performs a copy.
module dma_ctrl #(
   parameter int LEN_W = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] cpu_ab,
   input  logic [7:0]  cpu_do,
   input  logic        cpu_we,
   input  logic        cs,
   output logic [7:0]  dma_do,
   output logic        cpu_rdy,
   output logic [15:0] bus_ab,
   output logic [7:0]  bus_do,
   output logic        bus_we,
   input  logic [7:0]  bus_di,
   output logic        irq
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HOLD,
      ST_READ,
      ST_WRITE,
`ifdef DMA_FILL_EN
      ST_FILL,
`endif
      ST_RELEASE
   } state_t;

   state_t             state, state_next;
   logic [15:0]        src, dst;
   logic [LEN_W-1:0]   len;
   logic               irq_en, done;
   logic               fill_mode;
   logic [7:0]         fill_val;

   logic               reg_wr, ctrl_wr, start_req, len_zero, last_byte;
   logic               done_set, done_clr;
   logic [15:0]        len_ext;

   // Register writes are accepted only from an unstalled CPU while idle.
   assign reg_wr    = cs & cpu_we & cpu_rdy & (state == ST_IDLE);
   assign ctrl_wr   = reg_wr & (cpu_ab[2:0] == 3'd6);
   assign start_req = ctrl_wr & cpu_do[0];
   assign len_zero  = (len == '0);
   assign last_byte = (len == LEN_W'(1));
   assign len_ext   = 16'(len);

   // A zero-length START completes at once.  If a set and a clear of DONE
   // arrive together, the set takes priority.
   assign done_set  = (state == ST_RELEASE) | (start_req & len_zero);
   assign done_clr  = (ctrl_wr & cpu_do[2]) | (start_req & ~len_zero);

   assign irq = done & irq_en;

   // State register
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   // Next-state logic
   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (start_req && !len_zero) state_next = ST_HOLD;
`ifdef DMA_FILL_EN
         ST_HOLD:    state_next = fill_mode ? ST_FILL : ST_READ;
         ST_FILL:    if (last_byte) state_next = ST_RELEASE;
`else
         ST_HOLD:    state_next = ST_READ;
`endif
         ST_READ:    state_next = ST_WRITE;
         ST_WRITE:   state_next = last_byte ? ST_RELEASE : ST_READ;
         ST_RELEASE: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Bus ownership and CPU stall per state
   always_comb begin
      bus_ab  = cpu_ab;
      bus_do  = cpu_do;
      bus_we  = 1'b0;
      cpu_rdy = 1'b0;
      case (state)
         // Pass-through.  bus_we is gated by reset so a CPU write cannot leak during reset.
         ST_IDLE: begin
            cpu_rdy = 1'b1;
            bus_we  = cpu_we & reset_n;
         end
         ST_READ:  bus_ab = src;
         ST_WRITE: begin
            bus_ab = dst;
            bus_do = bus_di;
            bus_we = 1'b1;
         end
`ifdef DMA_FILL_EN
         ST_FILL: begin
            bus_ab = dst;
            bus_do = fill_val;
            bus_we = 1'b1;
         end
`endif
         // HOLD and RELEASE present the CPU address with writes blocked.
         default: ;
      endcase
   end

   // Programming registers and transfer progress counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src    <= '0;
         dst    <= '0;
         len    <= '0;
         irq_en <= 1'b0;
         done   <= 1'b0;
`ifdef DMA_FILL_EN
         fill_mode <= 1'b0;
         fill_val  <= '0;
`endif
      end else begin
         if (reg_wr) begin
            case (cpu_ab[2:0])
               3'd0: src[7:0]        <= cpu_do;
               3'd1: src[15:8]       <= cpu_do;
               3'd2: dst[7:0]        <= cpu_do;
               3'd3: dst[15:8]       <= cpu_do;
               3'd4: len[7:0]        <= cpu_do;
               3'd5: len[LEN_W-1:8]  <= cpu_do[LEN_W-9:0];
               3'd6: begin
                  irq_en <= cpu_do[1];
`ifdef DMA_FILL_EN
                  fill_mode <= cpu_do[3];
`endif
               end
`ifdef DMA_FILL_EN
               3'd7: fill_val <= cpu_do;
`endif
               default: ;
            endcase
         end
         if (state == ST_WRITE) begin
            src <= src + 16'd1;
            dst <= dst + 16'd1;
            len <= len - LEN_W'(1);
         end
`ifdef DMA_FILL_EN
         if (state == ST_FILL) begin
            dst <= dst + 16'd1;
            len <= len - LEN_W'(1);
         end
`endif
         if (done_set)      done <= 1'b1;
         else if (done_clr) done <= 1'b0;
      end
   end

`ifndef DMA_FILL_EN
   assign fill_mode = 1'b0;
   assign fill_val  = 8'h00;
`endif

   // Registered read port.  It tracks the addressed register every cycle, like RAM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dma_do <= '0;
      end else begin
         case (cpu_ab[2:0])
            3'd0: dma_do <= src[7:0];
            3'd1: dma_do <= src[15:8];
            3'd2: dma_do <= dst[7:0];
            3'd3: dma_do <= dst[15:8];
            3'd4: dma_do <= len_ext[7:0];
            3'd5: dma_do <= len_ext[15:8];
            3'd6: dma_do <= {4'b0000, fill_mode, done, irq_en, (state != ST_IDLE)};
            3'd7: dma_do <= fill_val;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: directed bench for dma_ctrl.
// The bench memory is a 64 KiB synchronous RAM whose read data lags the
// address by one cycle.  The reference model is a byte-level view of memory.
// From that view it predicts the ordered list of DMA writes and the final
// register values.
module tb_dma_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] cpu_ab = 16'h0000;
   logic [7:0]  cpu_do = 8'h00;
   logic        cpu_we = 1'b0;
   logic        cs = 1'b0;
   logic [7:0]  dma_do;
   logic        cpu_rdy;
   logic [15:0] bus_ab;
   logic [7:0]  bus_do;
   logic        bus_we;
   logic [7:0]  bus_di;
   logic        irq;

   localparam logic [15:0] REG_BASE = 16'hD000;
   localparam logic [15:0] LDA_ADDR = 16'h0500;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t         exp_q[$];
   logic [7:0]  mem[0:65535];
   logic [7:0]  model_mem[0:65535];
   logic [7:0]  mem_rd;
   int          n_checks = 0;
   int          n_errors = 0;

   dma_ctrl dut (
      .clk(clk), .reset_n(reset_n), .cpu_ab(cpu_ab), .cpu_do(cpu_do),
      .cpu_we(cpu_we), .cs(cs), .dma_do(dma_do), .cpu_rdy(cpu_rdy),
      .bus_ab(bus_ab), .bus_do(bus_do), .bus_we(bus_we), .bus_di(bus_di),
      .irq(irq)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pattern(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]       = pattern(16'(i));
         model_mem[i] = pattern(16'(i));
      end
   end

   // Synchronous RAM: write on the edge, read data valid the cycle after the address.
   always @(posedge clk) begin
      if (bus_we) mem[bus_ab] <= bus_do;
      mem_rd <= mem[bus_ab];
   end
   assign bus_di = mem_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle compare process.
   // While the CPU owns the bus, the outputs must show pure pass-through.
   // While the CPU is stalled, each write must be the next predicted DMA write.
   always @(negedge clk) begin
      if (!reset_n) begin
         check("reset_bus_we", bus_we, 1'b0);
         check("reset_cpu_rdy", cpu_rdy, 1'b1);
      end else if (cpu_rdy) begin
         check("pass_ab", bus_ab, cpu_ab);
         check("pass_do", bus_do, cpu_do);
         check("pass_we", bus_we, cpu_we);
      end else if (bus_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_dma_write_addr", bus_ab, 32'hDEAD_BEEF);
         end else begin
            check("dma_wr_addr", bus_ab, exp_q[0].a);
            check("dma_wr_data", bus_do, exp_q[0].d);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic cpu_write(input logic [2:0] idx, input logic [7:0] data);
      @(posedge clk); #1;
      cpu_ab = REG_BASE | 16'(idx);
      cpu_do = data;
      cpu_we = 1'b1;
      cs     = 1'b1;
      @(posedge clk); #1;
      cpu_we = 1'b0;
      cs     = 1'b0;
   endtask

   task automatic reg_read(input logic [2:0] idx, output logic [7:0] val);
      @(posedge clk); #1;
      cpu_ab = REG_BASE | 16'(idx);
      cs     = 1'b1;
      cpu_we = 1'b0;
      @(posedge clk); #1;
      val = dma_do;
      cs  = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [2:0] idx, input logic [7:0] exp);
      logic [7:0] v;
      reg_read(idx, v);
      check(name, v, exp);
   endtask

   task automatic setup(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
      cpu_write(3'd0, src[7:0]);
      cpu_write(3'd1, src[15:8]);
      cpu_write(3'd2, dst[7:0]);
      cpu_write(3'd3, dst[15:8]);
      cpu_write(3'd4, len[7:0]);
      cpu_write(3'd5, len[15:8]);
   endtask

   // Model of a copy: byte i of the destination gets the byte currently at src+i.
   // Memory is updated in order, so overlapping ranges are modelled correctly.
   task automatic queue_copy(input logic [15:0] src, input logic [15:0] dst, input int len);
      wr_t w;
      for (int i = 0; i < len; i++) begin
         w.a = dst + 16'(i);
         w.d = model_mem[src + 16'(i)];
         model_mem[w.a] = w.d;
         exp_q.push_back(w);
      end
   endtask

   task automatic queue_fill(input logic [15:0] dst, input int len, input logic [7:0] v);
      wr_t w;
      for (int i = 0; i < len; i++) begin
         w.a = dst + 16'(i);
         w.d = v;
         model_mem[w.a] = v;
         exp_q.push_back(w);
      end
   endtask

   // Start a transfer, then park the CPU on an LDA of LDA_ADDR.
   // Measure the stall, then check the byte the CPU receives on its first free cycle.
   task automatic run(input string name, input logic [7:0] ctrl, input int exp_low, input logic exp_irq);
      int   cnt = 0;
      int   guard = 0;
      logic irq_low_last = 1'b0;
      cpu_write(3'd6, ctrl);
      cpu_ab = LDA_ADDR;
      while (guard < exp_low + 20) begin
         @(negedge clk);
         guard++;
         if (!cpu_rdy) begin
            cnt++;
            irq_low_last = irq;
         end else if (cnt > 0) begin
            break;
         end
      end
      check({name, "_rdy_low"}, cnt, exp_low);
      check({name, "_lda_byte"}, bus_di, model_mem[LDA_ADDR]);
      check({name, "_irq_before_done"}, irq_low_last, 1'b0);
      check({name, "_irq_after"}, irq, exp_irq);
      check({name, "_writes_left"}, exp_q.size(), 0);
   endtask

   initial begin
      int cnt;
      int guard;

      // Reset state
      #3;
      check("rst_cpu_rdy", cpu_rdy, 1'b1);
      check("rst_bus_we", bus_we, 1'b0);
      check("rst_irq", irq, 1'b0);
      check("rst_dma_do", dma_do, 8'h00);
      @(negedge clk); #2 reset_n = 1'b1;
      read_check("rst_ctrl", 3'd6, 8'h00);

      // Basic copy of 4 ROM bytes to RAM
      setup(16'hF000, 16'h0200, 16'd4);
      queue_copy(16'hF000, 16'h0200, 4);
      run("copy4", 8'h01, 10, 1'b0);
      read_check("copy4_ctrl", 3'd6, 8'h04);
      read_check("copy4_len_lo", 3'd4, 8'h00);
      read_check("copy4_len_hi", 3'd5, 8'h00);
      read_check("copy4_dst_lo", 3'd2, 8'h04);
      read_check("copy4_dst_hi", 3'd3, 8'h02);
      read_check("copy4_src_lo", 3'd0, 8'h04);
      read_check("copy4_src_hi", 3'd1, 8'hF0);
      check("copy4_ram0", mem[16'h0200], 8'hCC);
      check("copy4_ram3", mem[16'h0203], 8'hCF);

      // Zero-length START: DONE on the next cycle, no stall, no DMA write
      cpu_write(3'd6, 8'h04);
      read_check("clr_ctrl", 3'd6, 8'h00);
      cpu_write(3'd6, 8'h01);
      read_check("len0_ctrl", 3'd6, 8'h04);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (!cpu_rdy) cnt++;
      end
      check("len0_rdy_low", cnt, 0);

      // IRQ behaviour around a 1-byte copy
      setup(16'h1000, 16'h6100, 16'd1);
      queue_copy(16'h1000, 16'h6100, 1);
      run("irq1", 8'h03, 4, 1'b1);
      read_check("irq1_ctrl", 3'd6, 8'h06);
      cpu_write(3'd6, 8'h04);
      check("irq_cleared", irq, 1'b0);
      cpu_write(3'd6, 8'h07);
      check("set_wins_irq", irq, 1'b1);
      read_check("set_wins_ctrl", 3'd6, 8'h06);

`ifdef DMA_FILL_EN
      // Fill across the 16-bit address wrap
      cpu_write(3'd7, 8'hA5);
      setup(16'h0000, 16'hFFFE, 16'd3);
      queue_fill(16'hFFFE, 3, 8'hA5);
      run("fill3", 8'h09, 5, 1'b0);
      read_check("fill3_dst_lo", 3'd2, 8'h01);
      read_check("fill3_dst_hi", 3'd3, 8'h00);
      read_check("fill3_fill", 3'd7, 8'hA5);
      read_check("fill3_ctrl", 3'd6, 8'h0C);
      check("fill3_ram", mem[16'h0000], 8'hA5);
`else
      // Without fill support, FILL_MODE is ignored and a copy runs
      cpu_write(3'd7, 8'hA5);
      setup(16'h1100, 16'h6200, 16'd3);
      queue_copy(16'h1100, 16'h6200, 3);
      run("nofill3", 8'h09, 8, 1'b0);
      read_check("nofill3_fill", 3'd7, 8'h00);
      read_check("nofill3_ctrl", 3'd6, 8'h04);
`endif

      // Reset during the third WRITE of an 8-byte copy
      setup(16'h3000, 16'h4000, 16'd8);
      queue_copy(16'h3000, 16'h4000, 8);
      cpu_write(3'd6, 8'h03);
      cnt = 0;
      guard = 0;
      while (cnt < 3 && guard < 40) begin
         @(negedge clk);
         guard++;
         if (bus_we && !cpu_rdy) cnt++;
      end
      check("rst_wait_writes", cnt, 3);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_cpu_rdy", cpu_rdy, 1'b1);
      check("midrst_bus_we", bus_we, 1'b0);
      check("midrst_irq", irq, 1'b0);
      check("midrst_dma_do", dma_do, 8'h00);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk); #2 reset_n = 1'b1;
      for (int i = 0; i < 8; i++) read_check("postrst_reg", 3'(i), 8'h00);
      repeat (10) @(negedge clk);

      // Overlapping copy that wraps both SRC and DST
      setup(16'hFFFE, 16'hFFFF, 16'd3);
      queue_copy(16'hFFFE, 16'hFFFF, 3);
      run("wrap3", 8'h01, 8, 1'b0);
      read_check("wrap3_src_lo", 3'd0, 8'h01);
      read_check("wrap3_src_hi", 3'd1, 8'h00);
      read_check("wrap3_dst_lo", 3'd2, 8'h02);
      read_check("wrap3_dst_hi", 3'd3, 8'h00);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
